// File: rtl/alu_req_arbiter.sv
// Shares one 8-bit ALU among NUM_REQ valid/ready requesters, one operation in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module alu_req_arbiter #(
    parameter int  NUM_REQ     = 4,
    parameter int  ALU_LATENCY = 0,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0] req_op,
    output logic [7:0]           alu_a_in,
    output logic [7:0]           alu_b_in,
    output logic [3:0]           alu_opcode_in,
    input  logic [7:0]           alu_y_out,
    input  logic                 alu_co_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_y,
    output logic                 rsp_co,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int unsigned NREQ     = NUM_REQ;
    localparam logic [2:0]  CNT_INIT = 3'(ALU_LATENCY);

    state_t         state, next_state;
    logic [2:0]     cnt;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           grant;
    logic [7:0]     sel_a, sel_b;
    logic [3:0]     sel_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && req_valid[i]) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;

    // Search starts just after the last granted requester and wraps around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= IDW'(NUM_REQ - 1);
        end else if (grant) begin
            ptr <= win_id;
        end
    end
`endif

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_id) begin
                sel_a  = req_a[8*i +: 8];
                sel_b  = req_b[8*i +: 8];
                sel_op = req_op[4*i +: 4];
            end
        end
    end

    // Gated by reset so no accept strobe can appear while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && reset) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign grant = |req_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a_in      <= '0;
            alu_b_in      <= '0;
            alu_opcode_in <= '0;
            rsp_y         <= '0;
            rsp_co        <= 1'b0;
            rsp_id        <= '0;
            cnt           <= '0;
        end else begin
            if (grant) begin
                alu_a_in      <= sel_a;
                alu_b_in      <= sel_b;
                alu_opcode_in <= sel_op;
                rsp_id        <= win_id;
                cnt           <= CNT_INIT;
            end
            if (state == WAIT) begin
                if (cnt == '0) begin
                    rsp_y  <= alu_y_out;
                    rsp_co <= alu_co_out;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
        end
    end

endmodule
